fp_align_pipe: RTL
==================

# fp_align_pipe

Pipelined, handshaked operand-alignment stage for the floating-point adder datapath. It takes two unpacked operands, orders them by magnitude, computes the exponent difference and right-shifts the smaller mantissa with guard/round/sticky generation. Its output feeds the mantissa adder/subtractor. Unlike the previous combinational aligner, it performs the operand swap itself, saturates shifts of any length correctly, and carries a 2-stage valid/ready pipeline with full back-pressure.

## Interface
- MAN_WIDTH, 11: mantissa width including hidden bit
- EXP_WIDTH, 5: biased exponent width
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous reset, active low
- in_valid  input  1  input operand pair valid
- in_ready  output  1  block can accept input this cycle
- exp_a, exp_b  input  EXP_WIDTH each  operand exponents
- man_a, man_b  input  MAN_WIDTH each  operand mantissas (hidden bit explicit)
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- exp_res  output  EXP_WIDTH  exponent of larger operand
- man_big  output  MAN_WIDTH  mantissa of larger operand, unshifted
- aligned_man  output  MAN_WIDTH+3  {shifted smaller mantissa, G, R, S}
- swapped  output  1  1 when operand b was the larger
- exp_diff  output  EXP_WIDTH  |exp_a - exp_b|

## Operation
- Stage 1 (S1): compare, swap, subtract. Larger = b if exp_b > exp_a, or exp_b == exp_a and man_b > man_a; else a (full tie → a, swapped=0). exp_diff = larger exp − smaller exp, unsigned, never negative.
- Stage 2 (S2): align. Form W = {man_small, 2'b00} (MAN_WIDTH+2 bits). Shifted = W >> exp_diff, using the full EXP_WIDTH shift amount. aligned_man[MAN_WIDTH+2:3] = Shifted[MAN_WIDTH+1:2]; G = Shifted[1]; R = Shifted[0]; S = OR of all bits of W shifted out.
- Saturation: exp_diff ≥ MAN_WIDTH+2 → mantissa, G, R = 0; S = |man_small. No wrap or truncation of the shift amount.
- exp_diff = 0 → aligned_man = {man_small, 3'b000}.
- All outputs except in_ready are registered in S2; exp_res, man_big, swapped, exp_diff travel with their data.
- Stage valids s1_v, s2_v are the only control state; no FSM beyond them.

## Timing
- Reset (rst_n low, asynchronous): s1_v = s2_v = 0; out_valid = 0; in_ready = 1; exp_res, man_big, aligned_man, exp_diff, swapped = 0. Data registers may hold old values only if valid clears, but must reset to 0.
- Transfer in: in_valid && in_ready at a rising edge. Transfer out: out_valid && out_ready.
- s2_load = s1_v && (!s2_v || out_ready). s1_load = !s1_v || s2_load. in_ready = s1_load (combinational from out_ready; no combinational path from in_valid to in_ready).
- Latency: 2 cycles from input transfer to out_valid with no stall. Throughput: 1 per cycle while out_ready = 1.
- Stall: out_ready = 0 holds all S2 outputs stable; S1 fills, then in_ready drops. Pipeline holds at most 2 items; nothing is dropped or duplicated.
- Simultaneous: S2 drains and refills from S1 in the same cycle while S1 accepts new input.
- out_valid stays high until transferred; outputs do not change while out_valid && !out_ready.
- rst_n asserted mid-operation discards in-flight items; first out_valid after release needs a new input plus 2 cycles.

## Test plan
- Basic align: exp_a=10, man_a=0x400, exp_b=8, man_b=0x600 → after 2 cycles exp_res=10, man_big=0x400, exp_diff=2, swapped=0, aligned_man=0x0C00.
- Swap and tie-break: exp_a=exp_b=15, man_a=0x500, man_b=0x7FF → swapped=1, man_big=0x7FF, aligned_man=0x2800; identical operands → swapped=0.
- Sticky edge: larger exp 20, smaller exp 8, man_small=0x401 (diff 12) → aligned_man=0x003 (R=1, S=1); diff 13 → 0x001; diff 31, man_small=0x400 → 0x001; man_small=0 → 0x000.
- Back-pressure: stream 8 random pairs back-to-back, hold out_ready=0 for 5 cycles mid-stream → in_ready drops after 2 accepts, outputs stable while stalled, all 8 results in order and matching a reference model.
- Reset: assert rst_n mid-stream with 2 items in flight → out_valid=0 and in_ready=1 immediately (asynchronous), no stale result after release.
- Random sweep: 10k random operands with random out_ready → scoreboard match, including every exp_diff 0..31.

Source files
------------

// File: rtl/fp_align_pipe.sv
// fp_align_pipe
//   Two-stage operand-alignment pipeline for the floating-point adder.
//   S1 orders the operands by magnitude and forms |exp_a - exp_b|.
//   S2 right-shifts the smaller mantissa by that amount. The shifted-out bits
//   become guard/round/sticky. The S2 registers drive every output except
//   in_ready.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   input handshake for one operand pair
//   exp_a/b, man_a/b    operands (mantissa has an explicit hidden bit)
//   out_valid/out_ready output handshake
//   exp_res             exponent of the larger operand
//   man_big             mantissa of the larger operand, unshifted
//   aligned_man         {shifted smaller mantissa, G, R, S}
//   swapped             1 when operand b was the larger
//   exp_diff            |exp_a - exp_b|
module fp_align_pipe #(
  parameter int MAN_WIDTH = 11,
  parameter int EXP_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_WIDTH-1:0] exp_a,
  input  logic [EXP_WIDTH-1:0] exp_b,
  input  logic [MAN_WIDTH-1:0] man_a,
  input  logic [MAN_WIDTH-1:0] man_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_WIDTH-1:0] exp_res,
  output logic [MAN_WIDTH-1:0] man_big,
  output logic [MAN_WIDTH+2:0] aligned_man,
  output logic                 swapped,
  output logic [EXP_WIDTH-1:0] exp_diff
);

  localparam int WW = MAN_WIDTH + 2;  // mantissa plus guard and round positions
  localparam int AW = MAN_WIDTH + 3;  // plus sticky

  // Shift {man, 2'b00} right by the full shift amount and OR every bit that
  // falls off the end into the sticky bit. An amount of WW or more clears the
  // shifted field. Sticky then covers the whole word. So long shifts saturate
  // without any separate clamp logic.
  function automatic logic [AW-1:0] align_shift(
    input logic [MAN_WIDTH-1:0] man_small,
    input logic [EXP_WIDTH-1:0] sh
  );
    logic [WW-1:0] w;
    logic [WW-1:0] shifted;
    logic          sticky;
    w       = {man_small, 2'b00};
    shifted = w >> sh;
    sticky  = 1'b0;
    for (int i = 0; i < WW; i++) begin
      if (i < int'(sh)) sticky = sticky | w[i];
    end
    return {shifted, sticky};
  endfunction

  logic s1_v;
  logic s2_v;
  logic s1_load;
  logic s2_load;

  logic [EXP_WIDTH-1:0] exp_big_p1;
  logic [EXP_WIDTH-1:0] exp_diff_p1;
  logic [MAN_WIDTH-1:0] man_big_p1;
  logic [MAN_WIDTH-1:0] man_small_p1;
  logic                 swapped_p1;

  logic                 b_larger;

  assign s2_load   = s1_v && (!s2_v || out_ready);
  assign s1_load   = !s1_v || s2_load;
  assign in_ready  = s1_load;
  assign out_valid = s2_v;

  // A full tie keeps operand a as the larger one.
  assign b_larger = (exp_b > exp_a) || ((exp_b == exp_a) && (man_b > man_a));

  // ---- S1: compare, swap, subtract ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v         <= 1'b0;
      exp_big_p1   <= '0;
      exp_diff_p1  <= '0;
      man_big_p1   <= '0;
      man_small_p1 <= '0;
      swapped_p1   <= 1'b0;
    end else if (s1_load) begin
      s1_v <= in_valid;
      if (in_valid) begin
        swapped_p1 <= b_larger;
        if (b_larger) begin
          exp_big_p1   <= exp_b;
          exp_diff_p1  <= exp_b - exp_a;
          man_big_p1   <= man_b;
          man_small_p1 <= man_a;
        end else begin
          exp_big_p1   <= exp_a;
          exp_diff_p1  <= exp_a - exp_b;
          man_big_p1   <= man_a;
          man_small_p1 <= man_b;
        end
      end
    end
  end

  // ---- S2: align ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v        <= 1'b0;
      exp_res     <= '0;
      man_big     <= '0;
      aligned_man <= '0;
      swapped     <= 1'b0;
      exp_diff    <= '0;
    end else if (s2_load) begin
      s2_v        <= 1'b1;
      exp_res     <= exp_big_p1;
      man_big     <= man_big_p1;
      aligned_man <= align_shift(man_small_p1, exp_diff_p1);
      swapped     <= swapped_p1;
      exp_diff    <= exp_diff_p1;
    end else if (out_ready) begin
      s2_v <= 1'b0;
    end
  end

endmodule
